// File: rtl/text_scroll_ctrl_pkg.sv
// Shared constants and state encoding for the text console scroll/clear sequencer.
package text_scroll_ctrl_pkg;

  localparam int unsigned TEXT_COLS        = 80;
  localparam int unsigned TEXT_ROWS        = 30;
  localparam int unsigned TEXT_SCREEN_SIZE = TEXT_COLS * TEXT_ROWS;
  localparam logic [15:0] TEXT_BLANK       = 16'h0720;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2,
    DONE    = 2'd3
  } scroll_state_t;

endpackage

// File: rtl/text_scroll_ctrl_fill_counter.sv
// Linear fill address generator: walks len consecutive addresses from start,
// advancing only on granted writes; last flags the final address of the run.
module fill_counter #(
  parameter int unsigned WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] start,
  input  logic [WIDTH-1:0] len,
  input  logic             step,
  output logic [WIDTH-1:0] addr,
  output logic             last
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] len_m1;

  // Load a new run, or advance address and count on each granted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      cnt    <= '0;
      len_m1 <= '0;
    end else if (load) begin
      addr   <= start;
      cnt    <= '0;
      len_m1 <= len - WIDTH'(1);
    end else if (step) begin
      addr <= addr + WIDTH'(1);
      cnt  <= cnt + WIDTH'(1);
    end
  end

  assign last = (cnt == len_m1);

endmodule

// File: rtl/text_scroll_ctrl.sv
// Scroll/clear sequencer for the circular VGA text buffer. Owns the ring top
// offset and blanks cells through a write port shared with the CPU.
module text_scroll_ctrl
  import text_scroll_ctrl_pkg::*;
#(
  parameter int unsigned      COLS   = TEXT_COLS,
  parameter int unsigned      ROWS   = TEXT_ROWS,
  parameter int unsigned      WIDTH  = 15,
  parameter int unsigned      DATA_W = 16,
  parameter logic [DATA_W-1:0] BLANK = DATA_W'(TEXT_BLANK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scroll_req,
  output logic              scroll_ack,
  input  logic              clear_req,
  output logic              clear_ack,
  output logic              busy,
  output logic [WIDTH-1:0]  win_start,
  output logic [WIDTH-1:0]  win_limit,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [WIDTH-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_data
);

  localparam int unsigned    SCREEN  = COLS * ROWS;
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(SCREEN);
  localparam logic [WIDTH-1:0] ROW_N = WIDTH'(COLS);

  scroll_state_t    state;
  logic             load;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] fill_start;
  logic [WIDTH-1:0] fill_len;
  logic [WIDTH:0]   start_sum;
  logic [WIDTH-1:0] start_next;

  // A new run starts only from IDLE; clear wins over scroll.
  assign load       = (state == IDLE) && (clear_req || scroll_req);
  assign fill_start = clear_req ? '0 : win_start;
  assign fill_len   = clear_req ? LIMIT : ROW_N;
  assign step       = mem_req && mem_gnt;

  assign mem_req   = (state == CLR_ROW) || (state == CLR_ALL);
  assign busy      = (state != IDLE);
  assign win_limit = LIMIT;
  assign mem_data  = BLANK;

  // Next ring top after a scroll, computed one bit wider so the compare cannot overflow.
  always_comb begin
    start_sum  = {1'b0, win_start} + (WIDTH+1)'(COLS);
    start_next = (start_sum == (WIDTH+1)'(SCREEN)) ? '0 : start_sum[WIDTH-1:0];
  end

  fill_counter #(
    .WIDTH (WIDTH)
  ) u_fill (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .start (fill_start),
    .len   (fill_len),
    .step  (step),
    .addr  (mem_addr),
    .last  (last)
  );

  // Sequencer: acks are raised on entry to DONE, so the ack itself tells DONE which
  // operation finished and therefore how to update the ring top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      win_start  <= '0;
      scroll_ack <= 1'b0;
      clear_ack  <= 1'b0;
    end else begin
      scroll_ack <= 1'b0;
      clear_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req)       state <= CLR_ALL;
          else if (scroll_req) state <= CLR_ROW;
        end
        CLR_ROW: begin
          if (step && last) begin
            state      <= DONE;
            scroll_ack <= 1'b1;
          end
        end
        CLR_ALL: begin
          if (step && last) begin
            state     <= DONE;
            clear_ack <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          win_start <= clear_ack ? '0 : start_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_scroll_ctrl.sv
// Randomized self-checking bench for text_scroll_ctrl against a queue-based model
// of expected write addresses and ring top offset.
module tb_text_scroll_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int SCR  = COLS * ROWS;
  localparam int W    = 15;
  localparam int DW   = 16;
  localparam logic [15:0] BLANK = 16'h0720;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scroll_req = 1'b0;
  logic          clear_req = 1'b0;
  logic          mem_gnt = 1'b0;
  logic          scroll_ack;
  logic          clear_ack;
  logic          busy;
  logic [W-1:0]  win_start;
  logic [W-1:0]  win_limit;
  logic          mem_req;
  logic [W-1:0]  mem_addr;
  logic [DW-1:0] mem_data;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int model_ws = 0;
  int nwr = 0;
  int exp_a;

  always #5 clk = ~clk;

  text_scroll_ctrl #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .WIDTH  (W),
    .DATA_W (DW),
    .BLANK  (BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scroll_req (scroll_req),
    .scroll_ack (scroll_ack),
    .clear_req  (clear_req),
    .clear_ack  (clear_ack),
    .busy       (busy),
    .win_start  (win_start),
    .win_limit  (win_limit),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Every granted write must be the next expected address with blank data.
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_gnt) begin
      nwr++;
      if (exp_q.size() == 0) begin
        chk("extra_write", exp_q.size(), 1);
      end else begin
        exp_a = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), exp_a);
        chk("wr_data", 32'(mem_data), 32'(BLANK));
      end
    end
  end

  task automatic push_op(input bit clr);
    if (clr) for (int i = 0; i < SCR; i++) exp_q.push_back(i);
    else     for (int i = 0; i < COLS; i++) exp_q.push_back(model_ws + i);
  endtask

  function automatic logic gnt_val(input int mode, input int idx);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      default: return ((idx % 3) == 0);
    endcase
  endfunction

  // Drive grants until an ack is seen; first posedge inside is the request sampling edge.
  task automatic await_ack(input bit clr, input int mode, input bit latchk);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 8000) begin
      @(posedge clk);
      #1 mem_gnt = gnt_val(mode, n);
      n++;
      @(negedge clk);
      if (scroll_ack || clear_ack) seen = 1;
    end
    if (!seen) begin
      chk("ack_seen", 32'(scroll_ack | clear_ack), 1);
    end else begin
      chk("ack_scroll", 32'(scroll_ack), 32'(!clr));
      chk("ack_clear", 32'(clear_ack), 32'(clr));
      chk("writes_left", exp_q.size(), 0);
      if (latchk) chk("ack_latency", n, (clr ? SCR : COLS) + 1);
      model_ws = clr ? 0 : (model_ws + COLS) % SCR;
    end
  endtask

  task automatic idle_check();
    @(posedge clk);
    @(negedge clk);
    chk("busy_after", 32'(busy), 0);
    chk("mem_req_after", 32'(mem_req), 0);
    chk("win_start", 32'(win_start), model_ws);
  endtask

  task automatic run_op(input bit clr, input int mode, input int hold, input bit latchk);
    push_op(clr);
    if (clr) clear_req = 1'b1;
    else     scroll_req = 1'b1;
    await_ack(clr, mode, latchk);
    if (hold == 0) begin
      if (clr) clear_req = 1'b0;
      else     scroll_req = 1'b0;
      idle_check();
    end else begin
      push_op(0);
      repeat (hold) begin
        @(posedge clk);
        @(negedge clk);
      end
      scroll_req = 1'b0;
      await_ack(0, 0, 0);
      idle_check();
    end
  endtask

  initial begin
    int base;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_win_start", 32'(win_start), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_acks", 32'({scroll_ack, clear_ack}), 0);
    chk("win_limit", 32'(win_limit), SCR);
    rst_n = 1'b1;

    // First scroll with latency, then walk the ring through its wrap.
    run_op(0, 0, 0, 1);
    chk("ws_first", 32'(win_start), COLS);
    for (int i = 2; i <= 29; i++) run_op(0, i % 3, 0, (i % 3) == 0);
    chk("ws_before_wrap", 32'(win_start), 2320);
    run_op(0, 0, 0, 1);
    chk("ws_wrapped", 32'(win_start), 0);

    // Simultaneous clear and scroll: clear first, then scroll from offset 0.
    run_op(0, 0, 0, 0);
    scroll_req = 1'b1;
    run_op(1, 0, 0, 1);
    run_op(0, 0, 0, 1);

    // Grant pattern 1,0,0 during a row clear.
    run_op(0, 2, 0, 0);

    // Random mix of operations with random grants.
    for (int i = 0; i < 6; i++) run_op($urandom_range(0, 5) == 0, 1, 0, 0);

    // Request held three cycles past ack starts exactly one more scroll.
    run_op(0, 0, 3, 0);
    repeat (4) @(negedge clk);
    chk("no_extra_op", 32'(busy), 0);

    // Reset in the middle of a row clear, with the request still held.
    run_op(0, 0, 0, 0);
    push_op(0);
    scroll_req = 1'b1;
    base = nwr;
    n = 0;
    while (nwr < base + 40 && n < 500) begin
      @(posedge clk);
      #1 mem_gnt = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("mid_writes", nwr - base, 40);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_mem_req", 32'(mem_req), 0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 0);
    chk("mid_rst_ws", 32'(win_start), 0);
    chk("mid_rst_ack", 32'(scroll_ack), 0);
    exp_q.delete();
    model_ws = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_op(0);
    await_ack(0, 0, 1);
    scroll_req = 1'b0;
    idle_check();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
